// File: rtl/delay_line_rt.sv
// Runtime-programmable, multi-lane, valid-gated delay line built on a circular buffer.
// Optional build macro DELAY_LINE_RT_ZERO_FILL_EN forces outputs to 0 until the line is primed.
module delay_line_rt #(
  parameter int DW      = 12,
  parameter int CH      = 2,
  parameter int MAX_LEN = 256,
  parameter int LEN_RST = 8,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LW-1:0]      len_in,
  input  logic               len_load,
  input  logic               valid_in,
  input  logic [CH*DW-1:0]   data_in,
  output logic               valid_out,
  output logic [CH*DW-1:0]   data_out,
  output logic               primed,
  output logic [LW-1:0]      len_cur
);

  localparam int W  = CH * DW;
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_RST_L = LW'(LEN_RST);

  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_PRIMED} fill_state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_BYP} src_t;

  logic [W-1:0]  mem [MAX_LEN];
  logic [W-1:0]  ram_q_reg;
  logic [W-1:0]  byp_reg;
  logic [AW-1:0] wp_reg;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] len_cur_reg;
  logic [LW-1:0] fill_reg;
  logic [LW-1:0] len_clamp;
  logic [LW-1:0] len_eff;
  logic [LW-1:0] fill_eff;
  logic [LW-1:0] fill_next;
  logic [LW-1:0] rd_diff;
  logic          valid_out_reg;
  logic          zero_sel;
  src_t          src_reg;
  src_t          src_next;
  fill_state_t   state_reg;
  fill_state_t   state_next;

  // A coincident len_load takes effect for the same strobe, so work from the post-load view.
  always_comb begin
    len_clamp = (len_in > MAX_LEN_L) ? MAX_LEN_L : len_in;
    len_eff   = len_load ? len_clamp : len_cur_reg;
    fill_eff  = len_load ? '0 : fill_reg;
    fill_next = fill_eff;
    if (valid_in && (fill_eff < len_eff)) begin
      fill_next = fill_eff + 1'b1;
    end
    rd_diff = LW'(wp_reg) - len_eff;
    rd_addr = rd_diff[AW-1:0];

    if (fill_next == len_eff) begin
      state_next = S_PRIMED;
    end else if (fill_next == '0) begin
      state_next = S_EMPTY;
    end else begin
      state_next = S_FILLING;
    end

`ifdef DELAY_LINE_RT_ZERO_FILL_EN
    zero_sel = (fill_eff < len_eff);
`else
    zero_sel = 1'b0;
`endif

    if (len_eff == '0) begin
      src_next = SRC_BYP;
    end else if (zero_sel) begin
      src_next = SRC_ZERO;
    end else begin
      src_next = SRC_RAM;
    end
  end

  // Read-first block RAM: with len_cur == MAX_LEN the read returns the entry being overwritten.
  always_ff @(posedge clk) begin
    if (valid_in && !rst) begin
      ram_q_reg    <= mem[rd_addr];
      mem[wp_reg]  <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_reg        <= '0;
      len_cur_reg   <= LEN_RST_L;
      fill_reg      <= '0;
      state_reg     <= (LEN_RST == 0) ? S_PRIMED : S_EMPTY;
      valid_out_reg <= 1'b0;
      src_reg       <= SRC_ZERO;
      byp_reg       <= '0;
    end else begin
      valid_out_reg <= valid_in;
      fill_reg      <= fill_next;
      state_reg     <= state_next;
      if (len_load) begin
        len_cur_reg <= len_clamp;
      end
      if (valid_in) begin
        wp_reg  <= wp_reg + 1'b1;
        byp_reg <= data_in;
        src_reg <= src_next;
      end
    end
  end

  // The RAM output register cannot be reset, so a registered source select provides the reset value.
  always_comb begin
    data_out = '0;
    case (src_reg)
      SRC_RAM: data_out = ram_q_reg;
      SRC_BYP: data_out = byp_reg;
      default: data_out = '0;
    endcase
  end

  assign valid_out = valid_out_reg;
  assign primed    = (state_reg == S_PRIMED);
  assign len_cur   = len_cur_reg;

endmodule

// File: tb/tb_delay_line_rt.sv
// Directed self-checking bench for delay_line_rt (default parameters, 24-bit I/Q samples).
module tb_delay_line_rt;
  localparam int LW = 9;
  localparam int W  = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] len_in;
  logic          len_load;
  logic          valid_in;
  logic [W-1:0]  data_in;
  logic          valid_out;
  logic [W-1:0]  data_out;
  logic          primed;
  logic [LW-1:0] len_cur;

  int tests_run    = 0;
  int tests_failed = 0;

  delay_line_rt dut (
    .clk       (clk),
    .rst       (rst),
    .len_in    (len_in),
    .len_load  (len_load),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .primed    (primed),
    .len_cur   (len_cur)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int k);
    return {12'(k + 2048), 12'(k)};
  endfunction

  // Drive one cycle at the falling edge; outputs are stable 1 ns after the rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic ld, input logic [LW-1:0] l);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    len_load = ld;
    len_in   = l;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    len_load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_in = 1'b0; len_load = 1'b0; len_in = '0; data_in = '0;
    #12;
    tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_out got %b exp 0", valid_out); end
    tests_run++; if (data_out !== '0) begin tests_failed++; $display("FAIL reset_data_out got %h exp 0", data_out); end
    tests_run++; if (primed !== 1'b0) begin tests_failed++; $display("FAIL reset_primed got %b exp 0", primed); end
    tests_run++; if (len_cur !== 9'd8) begin tests_failed++; $display("FAIL reset_len_cur got %0d exp 8", len_cur); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_length;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, mk(k), 1'b0, '0);
      tests_run++; if (valid_out !== 1'b1) begin tests_failed++; $display("FAIL rl_valid k=%0d got %b exp 1", k, valid_out); end
      tests_run++; if (primed !== (k >= 7)) begin tests_failed++; $display("FAIL rl_primed k=%0d got %b exp %b", k, primed, k >= 7); end
      if (k >= 8) begin
        tests_run++; if (data_out !== mk(k - 8)) begin tests_failed++; $display("FAIL rl_data k=%0d got %h exp %h", k, data_out, mk(k - 8)); end
      end
`ifdef DELAY_LINE_RT_ZERO_FILL_EN
      else begin
        tests_run++; if (data_out !== '0) begin tests_failed++; $display("FAIL rl_zero k=%0d got %h exp 0", k, data_out); end
      end
`endif
    end
  endtask

  task automatic test_gapped;
    step(1'b0, '0, 1'b1, 9'd4);
    tests_run++; if (len_cur !== 9'd4) begin tests_failed++; $display("FAIL gap_len got %0d exp 4", len_cur); end
    tests_run++; if (primed !== 1'b0) begin tests_failed++; $display("FAIL gap_flush_primed got %b exp 0", primed); end
    tests_run++; if (data_out !== mk(11)) begin tests_failed++; $display("FAIL gap_load_hold got %h exp %h", data_out, mk(11)); end
    for (int k = 0; k < 12; k++) begin
      step(1'b1, mk(100 + k), 1'b0, '0);
      tests_run++; if (valid_out !== 1'b1) begin tests_failed++; $display("FAIL gap_valid k=%0d got %b exp 1", k, valid_out); end
      tests_run++; if (primed !== (k >= 3)) begin tests_failed++; $display("FAIL gap_primed k=%0d got %b exp %b", k, primed, k >= 3); end
      if (k >= 4) begin
        tests_run++; if (data_out !== mk(96 + k)) begin tests_failed++; $display("FAIL gap_data k=%0d got %h exp %h", k, data_out, mk(96 + k)); end
      end
      for (int g = 0; g < 2; g++) begin
        step(1'b0, mk(999), 1'b0, '0);
        tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL gap_idle_valid k=%0d got %b exp 0", k, valid_out); end
        if (k >= 4) begin
          tests_run++; if (data_out !== mk(96 + k)) begin tests_failed++; $display("FAIL gap_hold k=%0d got %h exp %h", k, data_out, mk(96 + k)); end
        end
      end
    end
  endtask

  task automatic test_len_zero;
    step(1'b0, '0, 1'b1, 9'd0);
    tests_run++; if (primed !== 1'b1) begin tests_failed++; $display("FAIL z_primed_load got %b exp 1", primed); end
    tests_run++; if (len_cur !== 9'd0) begin tests_failed++; $display("FAIL z_len got %0d exp 0", len_cur); end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, mk(200 + k), 1'b0, '0);
      tests_run++; if (data_out !== mk(200 + k)) begin tests_failed++; $display("FAIL z_data k=%0d got %h exp %h", k, data_out, mk(200 + k)); end
      tests_run++; if (primed !== 1'b1) begin tests_failed++; $display("FAIL z_primed k=%0d got %b exp 1", k, primed); end
    end
  endtask

  task automatic test_len_max;
    step(1'b0, '0, 1'b1, 9'd300);
    tests_run++; if (len_cur !== 9'd256) begin tests_failed++; $display("FAIL clamp_len got %0d exp 256", len_cur); end
    tests_run++; if (primed !== 1'b0) begin tests_failed++; $display("FAIL max_flush_primed got %b exp 0", primed); end
    for (int k = 0; k < 600; k++) begin
      step(1'b1, mk(k), 1'b0, '0);
      tests_run++; if (primed !== (k >= 255)) begin tests_failed++; $display("FAIL max_primed k=%0d got %b exp %b", k, primed, k >= 255); end
      if (k >= 256) begin
        tests_run++; if (data_out !== mk(k - 256)) begin tests_failed++; $display("FAIL max_data k=%0d got %h exp %h", k, data_out, mk(k - 256)); end
      end
    end
  endtask

  task automatic test_load_during_stream;
    step(1'b0, '0, 1'b1, 9'd8);
    for (int k = 0; k < 50; k++) begin
      step(1'b1, mk(1000 + k), 1'b0, '0);
    end
    tests_run++; if (primed !== 1'b1) begin tests_failed++; $display("FAIL lds_pre_primed got %b exp 1", primed); end
    tests_run++; if (data_out !== mk(1041)) begin tests_failed++; $display("FAIL lds_pre_data got %h exp %h", data_out, mk(1041)); end
    for (int j = 0; j < 10; j++) begin
      step(1'b1, mk(2000 + j), (j == 0), 9'd3);
      tests_run++; if (primed !== (j >= 2)) begin tests_failed++; $display("FAIL lds_primed j=%0d got %b exp %b", j, primed, j >= 2); end
      if (j >= 3) begin
        tests_run++; if (data_out !== mk(1997 + j)) begin tests_failed++; $display("FAIL lds_data j=%0d got %h exp %h", j, data_out, mk(1997 + j)); end
      end
`ifdef DELAY_LINE_RT_ZERO_FILL_EN
      else begin
        tests_run++; if (data_out !== '0) begin tests_failed++; $display("FAIL lds_zero j=%0d got %h exp 0", j, data_out); end
      end
`endif
    end
    tests_run++; if (len_cur !== 9'd3) begin tests_failed++; $display("FAIL lds_len got %0d exp 3", len_cur); end
  endtask

  task automatic test_async_reset;
    step(1'b1, mk(2500), 1'b0, '0);
    step(1'b0, '0, 1'b1, 9'd5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL ar_valid got %b exp 0", valid_out); end
    tests_run++; if (data_out !== '0) begin tests_failed++; $display("FAIL ar_data got %h exp 0", data_out); end
    tests_run++; if (primed !== 1'b0) begin tests_failed++; $display("FAIL ar_primed got %b exp 0", primed); end
    tests_run++; if (len_cur !== 9'd8) begin tests_failed++; $display("FAIL ar_len got %0d exp 8", len_cur); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (len_cur !== 9'd8) begin tests_failed++; $display("FAIL ar_len_release got %0d exp 8", len_cur); end
    for (int k = 0; k < 10; k++) begin
      step(1'b1, mk(3000 + k), 1'b0, '0);
      tests_run++; if (primed !== (k >= 7)) begin tests_failed++; $display("FAIL ar_primed k=%0d got %b exp %b", k, primed, k >= 7); end
      if (k >= 8) begin
        tests_run++; if (data_out !== mk(2992 + k)) begin tests_failed++; $display("FAIL ar_data k=%0d got %h exp %h", k, data_out, mk(2992 + k)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_length();
    test_gapped();
    test_len_zero();
    test_len_max();
    test_load_during_stream();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
